adder_pipe_nbit: RTL and testbench
==================================

Name: adder_pipe_nbit

Overview:
- Parametrised, pipelined N-bit add/subtract unit.
- Generalises the team's 1-bit full adder cell to WIDTH bits, split into STAGES equal carry-pipelined chunks.
- Adds an add/subtract mode, a signed-overflow flag, and valid/ready handshakes on input and output.
- Sits between register-file style operand sources and result consumers in lab datapaths.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be an integer multiple of STAGES.
- STAGES, 2, number of pipeline stages; each stage computes CHUNK = WIDTH/STAGES bits. Legal range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  unit accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in (add) / borrow-in (sub)
- op  input  1  0 = a+b+c_in; 1 = a-b-c_in
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- c_out  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: rst_n low asynchronously clears every stage valid bit, so out_valid=0. sum, c_out and ovf reset to 0. in_ready is 1 while in reset-released idle. Datapath registers may also clear to 0.
- Operand conditioning at input:
  - b_eff = op ? ~b : b
  - cin_eff = op ? ~c_in : c_in
  - Result is a + b_eff + cin_eff.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff with the carry registered from stage k-1 (stage 0 uses cin_eff).
  - Registers the chunk sum and carry.
  - Forwards the remaining upper operand chunks and the already-computed lower sum chunks.
- Last stage also produces carry into MSB; ovf = carry_into_msb XOR c_out.
- Latency: exactly STAGES cycles from accepted input to out_valid, with no stalls.
- Handshake:
  - Global stall: advance = !out_valid || out_ready; in_ready = advance.
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - When advance=1, all stages shift and stage 0 captures the input beat, or a bubble (valid=0) if no transfer.
  - When advance=0, all stage registers hold.
- Bubbles propagate. Results are never dropped, duplicated or reordered.
- Output stability: while out_valid && !out_ready, sum, c_out and ovf hold constant.
- Throughput: one result per cycle when out_ready stays high.
- Simultaneous in-transfer and out-transfer with a full pipe is legal and sustains full rate.
- a, b, c_in and op are sampled only on a transfer. op applies per beat; mixing modes back-to-back is allowed.
- Reset mid-operation discards all in-flight beats. The first beat after reset release appears STAGES cycles after acceptance.
- STAGES=1: the unit is a single registered adder with the same handshake.
- Wrap-around: sum is taken modulo 2^WIDTH. Carry and overflow are reported only via c_out and ovf.

Decomposition:
- Shared package adder_pkg holds:
  - OP_ADD=1'b0 and OP_SUB=1'b1 constants.
  - A function computing CHUNK and a legality check (WIDTH % STAGES == 0), used by RTL and bench.
- One sub-module: adder_chunk #(CHUNK). Combinational CHUNK-bit ripple adder built from 1-bit full-adder cells; outputs the sum chunk, carry out, and carry into its MSB.
- Instantiate adder_chunk once per stage with a generate loop.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: a=FF, b=01, c_in=0, op=0 -> after 2 cycles out_valid=1, sum=00, c_out=1, ovf=0.
- a=7F, b=01, op=0, c_in=0 -> sum=80, c_out=0, ovf=1; then a=80, b=01, op=1, c_in=0 -> sum=7F, c_out=1, ovf=1.
- a=05, b=07, op=1, c_in=0 -> sum=FE, c_out=0, ovf=0; a=05, b=03, op=1, c_in=1 -> sum=01, c_out=1.
- Streaming 10 beats with in_valid=1, out_ready held low cycles 4-6 -> in_ready drops while the pipe is full, outputs hold stable, and all 10 results emerge in order with no loss or duplication.
- Exhaustive WIDTH=4, STAGES=4, random out_ready: all a, b, c_in, op combinations (1024 beats) -> every result matches the reference model, with latency 4 when unstalled.
- rst_n pulsed low mid-stream with 2 beats in flight -> out_valid=0 immediately (asynchronous). No stale beat appears after release, and the next accepted beat returns its correct result in 2 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and parameter helpers for the pipelined add/subtract unit.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits handled by each pipeline stage.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    // The width must split into equal, non-empty chunks.
    function automatic bit stages_legal(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from 1-bit full-adder cells.
module adder_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : gen_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[CHUNK];
    // Carry into the top bit of this chunk; only meaningful for overflow on the last chunk.
    assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit add/subtract unit with valid/ready handshakes and a global stall.
module adder_pipe_nbit
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (!stages_legal(WIDTH, STAGES)) begin : gen_param_check
        $error("adder_pipe_nbit: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             ovf_q;

    // Subtraction is a + ~b + ~borrow, so one adder serves both modes.
    assign b_eff    = (op == OP_SUB) ? ~b : b;
    assign cin_eff  = (op == OP_SUB) ? ~c_in : c_in;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        // Operand bits not yet summed when entering this stage, and result bits after it.
        localparam int unsigned WIN = WIDTH - k * CHUNK;
        localparam int unsigned SW  = (k + 1) * CHUNK;

        logic [WIN-1:0]   a_in;
        logic [WIN-1:0]   b_in;
        logic             ci;
        logic             valid_d;
        logic [CHUNK-1:0] s;
        logic             co;
        logic             cm;
        logic [SW-1:0]    sum_d;
        logic [SW-1:0]    sum_q;
        logic             valid_q;
        logic             carry_q;

        if (k == 0) begin : gen_head
            assign a_in    = a;
            assign b_in    = b_eff;
            assign ci      = cin_eff;
            assign valid_d = in_valid;
            assign sum_d   = s;
        end else begin : gen_tail
            assign a_in    = gen_stage[k-1].gen_fwd.a_rem_q;
            assign b_in    = gen_stage[k-1].gen_fwd.b_rem_q;
            assign ci      = gen_stage[k-1].carry_q;
            assign valid_d = gen_stage[k-1].valid_q;
            assign sum_d   = {s, gen_stage[k-1].sum_q};
        end

        adder_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a    (a_in[CHUNK-1:0]),
            .b    (b_in[CHUNK-1:0]),
            .c_in (ci),
            .sum  (s),
            .c_out(co),
            .c_msb(cm)
        );

        if (k < STAGES - 1) begin : gen_fwd
            logic [WIN-CHUNK-1:0] a_rem_q;
            logic [WIN-CHUNK-1:0] b_rem_q;
            logic                 unused_cm;

            assign unused_cm = cm;

            // Carry the still-unsummed upper operand bits to the next stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else if (advance) begin
                    a_rem_q <= a_in[WIN-1:CHUNK];
                    b_rem_q <= b_in[WIN-1:CHUNK];
                end
            end
        end

        // Stage register: valid bit, chunk carry and the accumulated low result bits.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= valid_d;
                carry_q <= co;
                sum_q   <= sum_d;
            end
        end
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= gen_stage[STAGES-1].cm ^ gen_stage[STAGES-1].co;
        end
    end

    assign out_valid = gen_stage[STAGES-1].valid_q;
    assign sum       = gen_stage[STAGES-1].sum_q;
    assign c_out     = gen_stage[STAGES-1].carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit: an 8-bit/2-stage and a 4-bit/4-stage instance against an
// arithmetic reference model with a scoreboard, stall and reset scenarios.
module tb_adder_pipe_nbit;
    import adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       c_in8 = 1'b0, op8 = 1'b0, c_out8, ovf8;

    logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       c_in4 = 1'b0, op4 = 1'b0, c_out4, ovf4;

    typedef struct {
        logic [9:0] res;
        int         acc_cyc;
        int         acc_stall;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       op;
        logic [9:0] res;
    } vec_t;

    exp_t       q8[$];
    exp_t       q4[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         rdy_mode = 0;
    int         t0 = 0;
    int         stalls[2] = '{0, 0};
    int         blocked[2] = '{0, 0};
    int         n_out[2] = '{0, 0};
    bit         prev_hold[2] = '{0, 0};
    logic [9:0] prev_val[2];

    adder_pipe_nbit #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .c_in(c_in8), .op(op8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .c_out(c_out8), .ovf(ovf8)
    );

    adder_pipe_nbit #(.WIDTH(4), .STAGES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .c_in(c_in4), .op(op4), .out_valid(out_valid4),
        .out_ready(out_ready4), .sum(sum4), .c_out(c_out4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Packed {c_out, ovf, sum} from plain integer arithmetic.
    function automatic logic [9:0] ref_model(input int w, input int a, input int b,
                                             input int cin, input int op);
        int m = 1 << w;
        int h = 1 << (w - 1);
        int sa = (a >= h) ? a - m : a;
        int sb = (b >= h) ? b - m : b;
        int full;
        int sres;
        int s;
        logic co;
        logic ov;
        if (op == 0) begin
            full = a + b + cin;
            sres = sa + sb + cin;
            co   = (full >= m);
        end else begin
            full = a - b - cin;
            sres = sa - sb - cin;
            co   = (full >= 0);
        end
        s  = ((full % m) + m) % m;
        ov = (sres >= h) || (sres < -h);
        return {co, ov, s[7:0]};
    endfunction

    // Per-cycle scoreboard for one instance, sampled mid-cycle.
    task automatic mon(input int sel);
        logic       ov, ordy, ir, iv;
        logic [9:0] now;
        int         w, stg, aa, bb, ci, o;
        exp_t       e;
        if (sel == 0) begin
            ov = out_valid8; ordy = out_ready8; ir = in_ready8; iv = in_valid8;
            now = {c_out8, ovf8, sum8}; w = 8; stg = 2;
            aa = int'(a8); bb = int'(b8); ci = int'(c_in8); o = int'(op8);
        end else begin
            ov = out_valid4; ordy = out_ready4; ir = in_ready4; iv = in_valid4;
            now = {c_out4, ovf4, 4'b0000, sum4}; w = 4; stg = 4;
            aa = int'(a4); bb = int'(b4); ci = int'(c_in4); o = int'(op4);
        end
        if (!rst_n) begin
            prev_hold[sel] = 1'b0;
            return;
        end
        if (prev_hold[sel]) check(sel == 0 ? "hold8" : "hold4", {ov, now}, {1'b1, prev_val[sel]});
        check(sel == 0 ? "in_ready8" : "in_ready4", ir, !ov || ordy);
        if (ov && ordy) begin
            if ((sel == 0 && q8.size() == 0) || (sel == 1 && q4.size() == 0)) begin
                check(sel == 0 ? "spurious8" : "spurious4", 1, 0);
            end else begin
                if (sel == 0) e = q8.pop_front();
                else e = q4.pop_front();
                check(sel == 0 ? "result8" : "result4", now, e.res);
                check(sel == 0 ? "latency8" : "latency4", cyc - e.acc_cyc,
                      stg + stalls[sel] - e.acc_stall);
                n_out[sel]++;
            end
        end
        if (iv && ir) begin
            e.res       = ref_model(w, aa, bb, ci, o);
            e.acc_cyc   = cyc;
            e.acc_stall = stalls[sel];
            if (sel == 0) q8.push_back(e);
            else q4.push_back(e);
        end
        if (iv && !ir) blocked[sel]++;
        if (ov && !ordy) stalls[sel]++;
        prev_hold[sel] = ov && !ordy;
        prev_val[sel]  = now;
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Consumer back-pressure: always ready, a fixed stall window, or random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: out_ready8 = !((cyc - t0) >= 4 && (cyc - t0) <= 6);
            2: begin
                out_ready8 = ($urandom_range(0, 3) != 0);
                out_ready4 = ($urandom_range(0, 3) != 0);
            end
            default: begin
                out_ready8 = 1'b1;
                out_ready4 = 1'b1;
            end
        endcase
    end

    task automatic drive_beat(input int sel, input logic [7:0] da, input logic [7:0] db,
                              input logic dc, input logic dop);
        bit ok = 1'b0;
        if (sel == 0) begin
            in_valid8 = 1'b1; a8 = da; b8 = db; c_in8 = dc; op8 = dop;
        end else begin
            in_valid4 = 1'b1; a4 = da[3:0]; b4 = db[3:0]; c_in4 = dc; op4 = dop;
        end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (sel == 0) ? in_ready8 : in_ready4;
            @(posedge clk);
            #1;
        end
        if (!ok) check("accept_timeout", 0, 1);
        if (sel == 0) in_valid8 = 1'b0;
        else in_valid4 = 1'b0;
    endtask

    task automatic drain(input int sel);
        int left = 1;
        for (int i = 0; i < 300 && left != 0; i++) begin
            @(negedge clk);
            left = (sel == 0) ? q8.size() : q4.size();
        end
        @(negedge clk);
        check("drain", (sel == 0) ? q8.size() : q4.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input logic [7:0] da, input logic [7:0] db, input logic dc,
                            input logic dop, input logic [9:0] exp);
        int n;
        bit seen = 1'b0;
        drive_beat(0, da, db, dc, dop);
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (out_valid8) begin
                seen = 1'b1;
                break;
            end
        end
        check("dir_latency", seen ? n : 99, 2);
        check("dir_result", {c_out8, ovf8, sum8}, exp);
        @(posedge clk);
        #1;
    endtask

    vec_t dir[7] = '{
        '{8'hFF, 8'h01, 1'b0, OP_ADD, 10'h200},
        '{8'h7F, 8'h01, 1'b0, OP_ADD, 10'h180},
        '{8'h80, 8'h01, 1'b0, OP_SUB, 10'h37F},
        '{8'h05, 8'h07, 1'b0, OP_SUB, 10'h0FE},
        '{8'h05, 8'h03, 1'b1, OP_SUB, 10'h201},
        '{8'h00, 8'h00, 1'b1, OP_SUB, 10'h0FF},
        '{8'h80, 8'h80, 1'b0, OP_ADD, 10'h300}
    };

    initial begin
        int base;
        #1;
        check("rst_out_valid", out_valid8, 0);
        check("rst_sum", sum8, 0);
        check("rst_c_out", c_out8, 0);
        check("rst_ovf", ovf8, 0);
        check("rst_in_ready", in_ready8, 1);
        check("rst_out_valid4", out_valid4, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready8, 1);
        check("idle_out_valid", out_valid8, 0);

        foreach (dir[i]) directed(dir[i].a, dir[i].b, dir[i].cin, dir[i].op, dir[i].res);

        // Ten back-to-back beats with a consumer stall while the pipe is full.
        base = n_out[0];
        blocked[0] = 0;
        t0 = cyc;
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) begin
            drive_beat(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        drain(0);
        check("stream_count", n_out[0] - base, 10);
        check("stream_in_ready_drop", blocked[0] > 0, 1);

        // Random traffic with random back-pressure and input gaps.
        rdy_mode = 2;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            drive_beat(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        drain(0);

        // Asynchronous reset with two beats in flight.
        rdy_mode = 0;
        @(posedge clk);
        #1;
        drive_beat(0, 8'h11, 8'h22, 1'b0, OP_ADD);
        drive_beat(0, 8'h40, 8'h05, 1'b0, OP_ADD);
        check("pre_rst_valid", out_valid8, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid8, 0);
        check("rst_async_sum", sum8, 0);
        q8.delete();
        q4.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", out_valid8, 0);
        directed(8'h12, 8'h34, 1'b0, OP_ADD, 10'h046);

        // Exhaustive 4-bit, 4-stage operand space under random back-pressure.
        base = n_out[1];
        rdy_mode = 2;
        for (int i = 0; i < 1024; i++) begin
            drive_beat(1, 8'(i & 15), 8'((i >> 4) & 15), 1'((i >> 8) & 1), 1'((i >> 9) & 1));
        end
        drain(1);
        check("exh_count", n_out[1] - base, 1024);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
